booth_mult_seq: RTL and testbench

//  Parametrised sequential radix-2 Booth multiplier; successor to the fixed 4-bit Booth FSM.

---
 rtl/booth_pkg.sv | 26 ++
 rtl/booth_r2_step.sv | 35 +++
 rtl/booth_mult_seq.sv | 116 +++++++++++
 tb/tb_booth_mult_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared encodings for the sequential Booth multiplier family: the controller
// state encoding and the radix-2 Booth pair opcodes.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;

  // Radix-2 Booth recoding of the pair {lo[0], q(-1)}.
  function automatic logic [1:0] booth_op(input logic lsb, input logic qm1);
    logic [1:0] op;
    case ({lsb, qm1})
      2'b10:   op = OP_SUB;
      2'b01:   op = OP_ADD;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_r2_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the sign-extended
// multiplicand into the guarded high half, then an arithmetic right shift of
// {hi, lo, q(-1)} by one bit. Purely combinational.
module booth_r2_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] hi_i,
  input  logic [WIDTH:0]   lo_i,
  input  logic             qm1_i,
  input  logic [WIDTH:0]   ye_i,
  output logic [WIDTH+1:0] hi_o,
  output logic [WIDTH:0]   lo_o,
  output logic             qm1_o
);

  logic [WIDTH+1:0] ye_sx;
  logic [WIDTH+1:0] sum;

  // Add/subtract per Booth pair, then shift right keeping the sign of hi.
  always_comb begin
    ye_sx = {ye_i[WIDTH], ye_i};
    sum   = hi_i;
    case (booth_op(lo_i[0], qm1_i))
      OP_ADD:  sum = hi_i + ye_sx;
      OP_SUB:  sum = hi_i - ye_sx;
      default: sum = hi_i;
    endcase
    hi_o  = {sum[WIDTH+1], sum[WIDTH+1:1]};
    lo_o  = {sum[0], lo_i[WIDTH:1]};
    qm1_o = lo_i[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
// Operands are extended by one bit (sign bit when signed, zero otherwise) so a
// single signed Booth datapath handles both modes; WIDTH+1 steps consume the
// extended multiplier and leave the exact product in the low 2*WIDTH bits.
//
// Handshake: an operation is accepted on a rising edge where start && in_ready
// (in_ready is high only in IDLE); the product is delivered on a rising edge
// where valid && z_ready. valid and z stay constant until that edge, and start
// is ignored outside IDLE.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               valid,
  input  logic               z_ready,
  output logic [2*WIDTH-1:0] z,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH+1:0]   hi_q, hi_d;
  logic [WIDTH:0]     lo_q, lo_d;
  logic               qm1_q, qm1_d;
  logic [WIDTH:0]     ye_q, ye_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  logic [WIDTH+1:0]   hi_nx;
  logic [WIDTH:0]     lo_nx;
  logic               qm1_nx;

  booth_r2_step #(.WIDTH(WIDTH)) u_step (
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .qm1_i (qm1_q),
    .ye_i  (ye_q),
    .hi_o  (hi_nx),
    .lo_o  (lo_nx),
    .qm1_o (qm1_nx)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign valid     = (state_q == ST_DONE);
  assign z         = z_q;
  assign dbg_state = state_q;

  // Next-state and datapath update: load on accept, step in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qm1_d   = qm1_q;
    ye_d    = ye_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE: begin
        if (start && in_ready) begin
          hi_d    = '0;
          lo_d    = {is_signed & x[WIDTH-1], x};
          ye_d    = {is_signed & y[WIDTH-1], y};
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        hi_d  = hi_nx;
        lo_d  = lo_nx;
        qm1_d = qm1_nx;
        cnt_d = cnt_q + CW'(1);
        // The (WIDTH+1)-th step has consumed every extended multiplier bit.
        if (cnt_q == CW'(WIDTH)) begin
          z_d     = {hi_nx[WIDTH-2:0], lo_nx};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (z_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
      ye_q    <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      ye_q    <= ye_d;
      z_q     <= z_d;
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq at WIDTH = 4, 8 and 16. One instance per width
// shares the clock, reset, operand and z_ready drivers; each has its own start.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8, start16;
  logic        is_signed;
  logic [15:0] x_drv, y_drv;
  logic        z_ready;

  logic        in_ready4, in_ready8, in_ready16;
  logic        valid4, valid8, valid16;
  logic [7:0]  z4;
  logic [15:0] z8;
  logic [31:0] z16;
  logic [1:0]  dbg4, dbg8, dbg16;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_ready(in_ready4),
    .is_signed(is_signed), .x(x_drv[3:0]), .y(y_drv[3:0]),
    .valid(valid4), .z_ready(z_ready), .z(z4), .dbg_state(dbg4)
  );

  booth_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_ready(in_ready8),
    .is_signed(is_signed), .x(x_drv[7:0]), .y(y_drv[7:0]),
    .valid(valid8), .z_ready(z_ready), .z(z8), .dbg_state(dbg8)
  );

  booth_mult_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .in_ready(in_ready16),
    .is_signed(is_signed), .x(x_drv), .y(y_drv),
    .valid(valid16), .z_ready(z_ready), .z(z16), .dbg_state(dbg16)
  );

  // ---------------- scoreboard / checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product: interpret operands as w-bit signed/unsigned integers.
  function automatic logic [31:0] model_mul(input int w, input logic sg,
                                            input logic [15:0] a, input logic [15:0] b);
    longint m, sa, sb, p;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sg && a[w-1]) sa = sa - (longint'(1) << w);
    if (sg && b[w-1]) sb = sb - (longint'(1) << w);
    p  = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic logic get_valid(input int w);
    case (w)
      4:       return valid4;
      8:       return valid8;
      default: return valid16;
    endcase
  endfunction

  function automatic logic get_in_ready(input int w);
    case (w)
      4:       return in_ready4;
      8:       return in_ready8;
      default: return in_ready16;
    endcase
  endfunction

  function automatic logic [31:0] get_z(input int w);
    case (w)
      4:       return {24'h0, z4};
      8:       return {16'h0, z8};
      default: return z16;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_start(input int w, input logic v);
    case (w)
      4:       start4  = v;
      8:       start8  = v;
      default: start16 = v;
    endcase
  endtask

  // One full operation, entered and left at a negedge with the DUT idle.
  // Holds z_ready low for bp cycles after valid, pulsing start meanwhile.
  task automatic run_op(input int w, input logic sg, input logic [15:0] xa,
                        input logic [15:0] ya, input logic [31:0] exp_z,
                        input int bp, input string tag);
    int lat;
    check_eq({tag, "_in_ready_pre"}, 32'(get_in_ready(w)), 32'd1);
    is_signed = sg;
    x_drv     = xa;
    y_drv     = ya;
    z_ready   = 1'b0;
    set_start(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(w, 1'b0);
    // Operands must not influence an operation already accepted.
    x_drv     = 16'($urandom);
    y_drv     = 16'($urandom);
    is_signed = 1'($urandom_range(0, 1));
    lat = 0;
    while (!get_valid(w) && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(w + 1));
    check_eq({tag, "_z"}, get_z(w), exp_z);
    for (int i = 0; i < bp; i++) begin
      set_start(w, 1'(i % 2));
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_bp_valid"}, 32'(get_valid(w)), 32'd1);
      check_eq({tag, "_bp_z"}, get_z(w), exp_z);
      check_eq({tag, "_bp_in_ready"}, 32'(get_in_ready(w)), 32'd0);
    end
    // Handshake with start raised on the same edge: start must be ignored.
    z_ready = 1'b1;
    set_start(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(w, 1'b0);
    z_ready = 1'b0;
    check_eq({tag, "_post_valid"}, 32'(get_valid(w)), 32'd0);
    check_eq({tag, "_post_in_ready"}, 32'(get_in_ready(w)), 32'd1);
    check_eq({tag, "_post_z_hold"}, get_z(w), exp_z);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    start4    = 1'b0;
    start8    = 1'b0;
    start16   = 1'b0;
    is_signed = 1'b0;
    x_drv     = '0;
    y_drv     = '0;
    z_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid4", 32'(valid4), 32'd0);
    check_eq("rst_valid8", 32'(valid8), 32'd0);
    check_eq("rst_valid16", 32'(valid16), 32'd0);
    check_eq("rst_z4", 32'(z4), 32'd0);
    check_eq("rst_z8", 32'(z8), 32'd0);
    check_eq("rst_z16", z16, 32'd0);
    check_eq("rst_in_ready4", 32'(in_ready4), 32'd1);
    check_eq("rst_state8", 32'(dbg8), 32'd0);

    // Directed vectors, hand-computed products.
    run_op(4, 1'b1, 16'h0008, 16'h0008, 32'h0000_0040, 0, "t1_s4_m8xm8");
    run_op(4, 1'b0, 16'h000F, 16'h000F, 32'h0000_00E1, 0, "t2_u4_15x15");
    run_op(4, 1'b1, 16'h000F, 16'h000F, 32'h0000_0001, 0, "t2_s4_m1xm1");
    run_op(4, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 0, "zero_u4");
    run_op(8, 1'b1, 16'h007F, 16'h0080, 32'h0000_C080, 0, "t3_s8_127xm128");
    run_op(8, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 0, "t3_u8_255x255");
    run_op(8, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000, 0, "s8_m128xm128");
    run_op(8, 1'b1, 16'h0080, 16'h0001, 32'h0000_FF80, 0, "s8_m128x1");
    run_op(8, 1'b1, 16'h0000, 16'h0080, 32'h0000_0000, 0, "zero_s8");
    run_op(16, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 0, "s16_minxmin");
    run_op(16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, "u16_ones");
    run_op(16, 1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000, 0, "s16_maxxmin");

    // Back-pressure: z_ready low for 10 cycles after valid; 5 x -3 = -15.
    run_op(8, 1'b1, 16'h0005, 16'h00FD, 32'h0000_FFF1, 10, "t4_bp");

    // Reset asserted during the third RUN cycle aborts the operation.
    is_signed = 1'b1;
    x_drv     = 16'h0005;
    y_drv     = 16'h0007;
    start4    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_rst_valid", 32'(valid4), 32'd0);
    check_eq("t5_rst_in_ready", 32'(in_ready4), 32'd1);
    check_eq("t5_rst_z", 32'(z4), 32'd0);
    check_eq("t5_rst_state", 32'(dbg4), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("t5_no_valid", 32'(valid4), 32'd0);
    end
    run_op(4, 1'b1, 16'h0003, 16'h000E, 32'h0000_00FA, 0, "t5_3xm2");

    // Exhaustive W=4 in both modes.
    for (int sg = 0; sg < 2; sg++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run_op(4, 1'(sg), 16'(a), 16'(b), model_mul(4, 1'(sg), 16'(a), 16'(b)), 0, "exh4");
        end
      end
    end

    // Random W=8 and W=16 operations with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      logic        sg;
      logic [15:0] a, b;
      sg = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 255));
      b  = 16'($urandom_range(0, 255));
      run_op(8, sg, a, b, model_mul(8, sg, a, b), int'($urandom_range(0, 3)), "rnd8");
    end
    for (int i = 0; i < 200; i++) begin
      logic        sg;
      logic [15:0] a, b;
      sg = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = 16'($urandom);
      run_op(16, sg, a, b, model_mul(16, sg, a, b), int'($urandom_range(0, 3)), "rnd16");
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
